// File: rtl/video_sprite_overlay_if.sv
// Video pixel bus between the sync generator/renderer and the sprite overlay.
// master: upstream timing + sprite control, consumes composited output.
// slave : the overlay stage itself.
//   i_hsync/i_vsync/i_visible/i_hpos/i_vpos : sync generator timing
//   i_bg_rgb                                : background colour for the pixel
//   i_sprite_x/i_sprite_y/i_sprite_en        : requested sprite placement
//   i_wr_en/i_wr_addr/i_wr_data              : bitmap write port
//   o_hsync/o_vsync/o_visible/o_rgb          : 2-cycle delayed, composited video
//   o_collision                              : collision seen in previous frame
interface video_sprite_overlay_if #(
    parameter int unsigned COLOR_BITS = 9
);
    logic                  i_hsync;
    logic                  i_vsync;
    logic                  i_visible;
    logic [9:0]            i_hpos;
    logic [9:0]            i_vpos;
    logic [COLOR_BITS-1:0] i_bg_rgb;
    logic [9:0]            i_sprite_x;
    logic [9:0]            i_sprite_y;
    logic                  i_sprite_en;
    logic                  i_wr_en;
    logic [7:0]            i_wr_addr;
    logic                  i_wr_data;
    logic                  o_hsync;
    logic                  o_vsync;
    logic                  o_visible;
    logic [COLOR_BITS-1:0] o_rgb;
    logic                  o_collision;

    modport master (
        output i_hsync, i_vsync, i_visible, i_hpos, i_vpos, i_bg_rgb,
               i_sprite_x, i_sprite_y, i_sprite_en,
               i_wr_en, i_wr_addr, i_wr_data,
        input  o_hsync, o_vsync, o_visible, o_rgb, o_collision
    );

    modport slave (
        input  i_hsync, i_vsync, i_visible, i_hpos, i_vpos, i_bg_rgb,
               i_sprite_x, i_sprite_y, i_sprite_en,
               i_wr_en, i_wr_addr, i_wr_data,
        output o_hsync, o_vsync, o_visible, o_rgb, o_collision
    );
endinterface

// File: rtl/video_sprite_overlay.sv
// Single 16x16 1bpp hardware sprite overlaid on the background pixel stream.
// Two-stage pipeline: stage 1 computes the sprite hit and issues the bitmap
// read, stage 2 composites. Sprite placement is latched once per frame at the
// start of vertical blank so moves never tear; collisions are reported per frame.
// Ports:
//   i_clk   : pixel clock
//   i_rst_n : synchronous active-low reset
//   bus     : pixel/control bus (slave side), see video_sprite_overlay_if
module video_sprite_overlay #(
    parameter int unsigned            COLOR_BITS   = 9,
    parameter int unsigned            V_VISIBLE    = 480,
    parameter logic [COLOR_BITS-1:0]  SPRITE_COLOR = COLOR_BITS'(9'h1FF)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    video_sprite_overlay_if.slave bus
);
    localparam int unsigned POS_W   = 10;
    localparam int unsigned SPR_DIM = 16;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DEPTH   = 256;

    // Frame-latched sprite placement
    logic [POS_W-1:0]      shadow_x;
    logic [POS_W-1:0]      shadow_y;
    logic                  shadow_en;

    // Stage 1 registers
    logic [COLOR_BITS-1:0] bg_d;
    logic                  hsync_d;
    logic                  vsync_d;
    logic                  visible_d;
    logic                  hit1_d;
    logic                  ram_q;

    logic                  collision_acc;

    logic                  mem [DEPTH];

    logic [POS_W-1:0]      dx_c;
    logic [POS_W-1:0]      dy_c;
    logic                  hit1_c;
    logic                  fb_c;
    logic [ADDR_W-1:0]     rd_addr_c;
    logic                  opaque_c;

    // Hit test against the latched placement; subtraction wraps modulo 1024
    always_comb begin
        fb_c      = (bus.i_vpos == POS_W'(V_VISIBLE)) && (bus.i_hpos == '0);
        dx_c      = bus.i_hpos - shadow_x;
        dy_c      = bus.i_vpos - shadow_y;
        hit1_c    = shadow_en && bus.i_visible &&
                    (dx_c < POS_W'(SPR_DIM)) && (dy_c < POS_W'(SPR_DIM));
        rd_addr_c = {dy_c[3:0], dx_c[3:0]};
        opaque_c  = hit1_d && ram_q;
    end

    // Bitmap storage: no reset, read-before-write on a same-address collision
    always_ff @(posedge i_clk) begin
        if (bus.i_wr_en) begin
            mem[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    // Frame-boundary latch of placement and collision reporting
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shadow_x        <= '0;
            shadow_y        <= '0;
            shadow_en       <= 1'b0;
            collision_acc   <= 1'b0;
            bus.o_collision <= 1'b0;
        end else if (fb_c) begin
            shadow_x        <= bus.i_sprite_x;
            shadow_y        <= bus.i_sprite_y;
            shadow_en       <= bus.i_sprite_en;
            bus.o_collision <= collision_acc;
            // Clear takes priority over a same-cycle collision
            collision_acc   <= 1'b0;
        end else if (opaque_c && (bg_d != '0)) begin
            collision_acc   <= 1'b1;
        end
    end

    // Stage 1: register timing, background, hit and bitmap read
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bg_d      <= '0;
            hsync_d   <= 1'b0;
            vsync_d   <= 1'b0;
            visible_d <= 1'b0;
            hit1_d    <= 1'b0;
            ram_q     <= 1'b0;
        end else begin
            bg_d      <= bus.i_bg_rgb;
            hsync_d   <= bus.i_hsync;
            vsync_d   <= bus.i_vsync;
            visible_d <= bus.i_visible;
            hit1_d    <= hit1_c;
            ram_q     <= mem[rd_addr_c];
        end
    end

    // Stage 2: composite; opaque implies visible so blanking forces black
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_hsync   <= 1'b0;
            bus.o_vsync   <= 1'b0;
            bus.o_visible <= 1'b0;
            bus.o_rgb     <= '0;
        end else begin
            bus.o_hsync   <= hsync_d;
            bus.o_vsync   <= vsync_d;
            bus.o_visible <= visible_d;
            if (opaque_c) begin
                bus.o_rgb <= SPRITE_COLOR;
            end else if (visible_d) begin
                bus.o_rgb <= bg_d;
            end else begin
                bus.o_rgb <= '0;
            end
        end
    end
endmodule
